// File: rtl/rvm_mem_responder_pkg.sv
// Shared memory-bus widths and the address-legality helper for rvm_mem_responder.
// The helper is only referenced when RVM_MEM_RESP_ERRCHK_EN is defined.
package rvm_mem_responder_pkg;

  localparam int RVM_MEM_ADDR_W = 32;
  localparam int RVM_MEM_DATA_W = 32;
  localparam int RVM_MEM_STRB_W = 4;

  // Misaligned, or beyond the 2^(depth_w+2)-byte window backed by the SRAM.
  function automatic logic addr_is_bad(input logic [RVM_MEM_ADDR_W-1:0] addr,
                                       input int                        depth_w);
    logic [RVM_MEM_ADDR_W-1:0] hi;
    hi = addr >> (depth_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/rvm_mem_responder.sv
// Single-outstanding core-to-synchronous-SRAM responder with optional wait states.
// Define RVM_MEM_RESP_ERRCHK_EN to reject misaligned / out-of-range addresses.
module rvm_mem_responder
  import rvm_mem_responder_pkg::*;
#(
  parameter int DEPTH_W     = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req,
  input  logic                      mem_wen,
  input  logic [RVM_MEM_ADDR_W-1:0] mem_addr,
  input  logic [RVM_MEM_DATA_W-1:0] mem_wdata,
  input  logic [RVM_MEM_STRB_W-1:0] mem_strb,
  output logic                      mem_ack,
  output logic [RVM_MEM_DATA_W-1:0] mem_rdata,
  output logic                      mem_error,
  output logic                      ram_cs,
  output logic [RVM_MEM_STRB_W-1:0] ram_we,
  output logic [DEPTH_W-1:0]        ram_addr,
  output logic [RVM_MEM_DATA_W-1:0] ram_wdata,
  input  logic [RVM_MEM_DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [3:0]                r_cnt;
  logic [3:0]                w_cnt_nxt;
  logic                      r_wen;
  logic [DEPTH_W-1:0]        r_addr;
  logic [RVM_MEM_DATA_W-1:0] r_wdata;
  logic [RVM_MEM_STRB_W-1:0] r_strb;
  logic                      w_take;
  logic                      w_err;
  logic                      r_err;

  assign w_take = (r_state == S_IDLE) && mem_req;

`ifdef RVM_MEM_RESP_ERRCHK_EN
  assign w_err = addr_is_bad(mem_addr, DEPTH_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_take) begin
      r_err <= w_err;
    end
  end
`else
  // Only the word-address bits reach the SRAM; the rest wrap away.
  logic w_unused;
  assign w_unused = &{1'b0, mem_addr[RVM_MEM_ADDR_W-1:DEPTH_W+2], mem_addr[1:0]};
  assign w_err    = 1'b0;
  assign r_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_take) begin
      r_wen   <= mem_wen;
      r_addr  <= mem_addr[DEPTH_W+1:2];
      r_wdata <= mem_wdata;
      r_strb  <= mem_strb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mem_error   = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = '0;
    ram_addr    = r_addr;
    ram_wdata   = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_cnt_nxt = WAIT_LOAD;
          if (w_err) begin
            w_state_nxt = S_RESP;
          end else if (HAS_WAIT) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        ram_cs      = 1'b1;
        ram_we      = r_wen ? r_strb : '0;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // SRAM read data arrives the cycle after chip select, i.e. here.
        mem_ack     = 1'b1;
        mem_error   = r_err;
        mem_rdata   = (r_wen || r_err) ? '0 : ram_rdata;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
